// File: rtl/fp_div_pkg.sv
// Shared types and widths for the FP divide normalize/round/pack stage.
// Build with FP_DIV_RNE_EN for round-to-nearest-even; default is truncate.
package fp_div_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_Q_W   = FP_MAN_W + 3;

   localparam logic [FP_MAN_W-1:0] QNAN_FRAC =
      {1'b1, {(FP_MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {
      CLS_NORM = 2'b00,
      CLS_ZERO = 2'b01,
      CLS_INF  = 2'b10,
      CLS_NAN  = 2'b11
   } cls_e;

   typedef struct packed {
      logic                       sign;
      cls_e                       cls;
      logic signed [FP_EXP_W+1:0] e;
      logic [FP_MAN_W-1:0]        frac;
      logic                       guard;
      logic                       sticky;
   } s1_beat_t;

endpackage

// File: rtl/fp_round_rne.sv
// Fraction rounding: RNE increment when FP_DIV_RNE_EN, else truncate.
// Inexact is guard|sticky in both modes.
module fp_round_rne
   import fp_div_pkg::*;
#(
   parameter int MAN_W = FP_MAN_W
) (
   input  logic [MAN_W-1:0] frac,
   input  logic             guard,
   input  logic             sticky,
   output logic [MAN_W-1:0] frac_rnd,
   output logic             carry,
   output logic             inexact
);

`ifdef FP_DIV_RNE_EN
   logic inc;
   assign inc = guard & (sticky | frac[0]);
   assign {carry, frac_rnd} =
      {1'b0, frac} + {{MAN_W{1'b0}}, inc};
`else
   assign carry    = 1'b0;
   assign frac_rnd = frac;
`endif

   assign inexact = guard | sticky;

endmodule

// File: rtl/fp_div_round.sv
// Two-stage normalize / round / pack pipeline after the mantissa divider.
// FP_DIV_RNE_EN selects RNE (overflow to inf); otherwise RTZ (saturate).
module fp_div_round
   import fp_div_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W,
   parameter int Q_W   = MAN_W + 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic signed [EXP_W+1:0] in_exp,
   input  logic [Q_W-1:0]          in_q,
   input  logic                    in_rem_nz,
   input  logic [1:0]              in_cls,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+MAN_W:0]    out_res,
   output logic                    out_of,
   output logic                    out_uf,
   output logic                    out_nx
);

   localparam logic signed [EXP_W+1:0] E_ONE  = 1;
   localparam logic signed [EXP_W+1:0] E_ZERO = '0;
   localparam logic signed [EXP_W+1:0] E_MAX  = (2**EXP_W) - 1;

   logic     s1_valid;
   logic     s1_adv;
   logic     s2_adv;
   s1_beat_t s1_nxt;
   s1_beat_t s1_q;

   assign s2_adv   = ~out_valid | out_ready;
   assign s1_adv   = ~s1_valid | s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      s1_nxt      = '0;
      s1_nxt.sign = in_sign;
      s1_nxt.cls  = cls_e'(in_cls);
      if (in_q[Q_W-1]) begin
         s1_nxt.frac   = in_q[MAN_W+1:2];
         s1_nxt.guard  = in_q[1];
         s1_nxt.sticky = in_q[0] | in_rem_nz;
         s1_nxt.e      = in_exp;
      end else begin
         s1_nxt.frac   = in_q[MAN_W:1];
         s1_nxt.guard  = in_q[0];
         s1_nxt.sticky = in_rem_nz;
         s1_nxt.e      = in_exp - E_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) s1_q <= s1_nxt;
      end
   end

   logic [MAN_W-1:0]        frac_rnd;
   logic                    rnd_carry;
   logic                    rnd_nx;
   logic signed [EXP_W+1:0] e_rnd;

   fp_round_rne #(.MAN_W(MAN_W)) u_rnd (
      .frac     (s1_q.frac),
      .guard    (s1_q.guard),
      .sticky   (s1_q.sticky),
      .frac_rnd (frac_rnd),
      .carry    (rnd_carry),
      .inexact  (rnd_nx)
   );

   // A rounding carry leaves frac_rnd all-zero, so only the exponent bumps.
   assign e_rnd = $signed(s1_q.e)
                + $signed({{(EXP_W+1){1'b0}}, rnd_carry});

   logic [EXP_W+MAN_W:0] res_nxt;
   logic                 of_nxt;
   logic                 uf_nxt;
   logic                 nx_nxt;

   always_comb begin
      res_nxt = '0;
      of_nxt  = 1'b0;
      uf_nxt  = 1'b0;
      nx_nxt  = 1'b0;
      unique case (s1_q.cls)
         CLS_NAN:  res_nxt = {1'b0, {EXP_W{1'b1}}, QNAN_FRAC};
         CLS_INF:  res_nxt = {s1_q.sign, {EXP_W{1'b1}},
                              {MAN_W{1'b0}}};
         CLS_ZERO: res_nxt = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
         default: begin
            if (e_rnd >= E_MAX) begin
               of_nxt = 1'b1;
               nx_nxt = 1'b1;
`ifdef FP_DIV_RNE_EN
               res_nxt = {s1_q.sign, {EXP_W{1'b1}},
                          {MAN_W{1'b0}}};
`else
               res_nxt = {s1_q.sign, {(EXP_W-1){1'b1}}, 1'b0,
                          {MAN_W{1'b1}}};
`endif
            end else if (e_rnd <= E_ZERO) begin
               uf_nxt  = 1'b1;
               nx_nxt  = 1'b1;
               res_nxt = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
            end else begin
               nx_nxt  = rnd_nx;
               res_nxt = {s1_q.sign, e_rnd[EXP_W-1:0], frac_rnd};
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_res   <= '0;
         out_of    <= 1'b0;
         out_uf    <= 1'b0;
         out_nx    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_res <= res_nxt;
            out_of  <= of_nxt;
            out_uf  <= uf_nxt;
            out_nx  <= nx_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fp_div_round.sv
// Directed bench for fp_div_round; expectations follow FP_DIV_RNE_EN.
module tb_fp_div_round;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [25:0] in_q;
   logic        in_rem_nz;
   logic [1:0]  in_cls;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic        out_of;
   logic        out_uf;
   logic        out_nx;

   int total = 0;
   int bad   = 0;

`ifdef FP_DIV_RNE_EN
   localparam logic [31:0] R_DIV13 = 32'h3EAAAAAB;
   localparam logic [31:0] R_CARRY = 32'h40000000;
   localparam logic [31:0] R_OVF   = 32'h7F800000;
   localparam logic [31:0] R_COVF  = 32'h7F800000;
   localparam logic [2:0]  F_COVF  = 3'b101;
`else
   localparam logic [31:0] R_DIV13 = 32'h3EAAAAAA;
   localparam logic [31:0] R_CARRY = 32'h3FFFFFFF;
   localparam logic [31:0] R_OVF   = 32'h7F7FFFFF;
   localparam logic [31:0] R_COVF  = 32'h7F7FFFFF;
   localparam logic [2:0]  F_COVF  = 3'b001;
`endif

   typedef struct packed {
      logic        s;
      logic [9:0]  e;
      logic [25:0] q;
      logic        rnz;
      logic [1:0]  c;
      logic [31:0] r;
      logic [2:0]  f;
   } vec_t;

   fp_div_round dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_q      (in_q),
      .in_rem_nz (in_rem_nz),
      .in_cls    (in_cls),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_of    (out_of),
      .out_uf    (out_uf),
      .out_nx    (out_nx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic drive(input vec_t v);
      in_sign   = v.s;
      in_exp    = v.e;
      in_q      = v.q;
      in_rem_nz = v.rnz;
      in_cls    = v.c;
   endtask

   task automatic run_one(input vec_t v, output logic [31:0] r,
                          output logic [2:0] f, output int lat);
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      r = out_res;
      f = {out_of, out_uf, out_nx};
   endtask

   task automatic test_reset;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drive('0);
      #12;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b exp=1", in_ready);
      end
      total++;
      if ({out_res, out_of, out_uf, out_nx} !== 35'd0) begin
         bad++;
         $display("FAIL reset_res got=%h exp=0", out_res);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_arith;
      vec_t        vt [15];
      logic [31:0] r;
      logic [2:0]  f;
      int          lat;
      vt[0]  = '{1'b0, 10'd128, 26'h2000000, 1'b0, 2'd0,
                 32'h40000000, 3'b000};
      vt[1]  = '{1'b0, 10'd126, 26'h1555555, 1'b1, 2'd0,
                 R_DIV13, 3'b001};
      vt[2]  = '{1'b0, 10'd127, 26'h3FFFFFF, 1'b1, 2'd0,
                 R_CARRY, 3'b001};
      vt[3]  = '{1'b0, 10'd300, 26'h2000000, 1'b0, 2'd0,
                 R_OVF, 3'b101};
      vt[4]  = '{1'b0, 10'd254, 26'h3FFFFFF, 1'b1, 2'd0,
                 R_COVF, F_COVF};
      vt[5]  = '{1'b0, 10'd254, 26'h2000000, 1'b0, 2'd0,
                 32'h7F000000, 3'b000};
      vt[6]  = '{1'b1, 10'd0, 26'h1555555, 1'b0, 2'd0,
                 32'h80000000, 3'b011};
      vt[7]  = '{1'b0, 10'd1, 26'h2000000, 1'b0, 2'd0,
                 32'h00800000, 3'b000};
      vt[8]  = '{1'b0, 10'd1, 26'h1000000, 1'b0, 2'd0,
                 32'h00000000, 3'b011};
      vt[9]  = '{1'b1, 10'h3F0, 26'h2000000, 1'b0, 2'd0,
                 32'h80000000, 3'b011};
      vt[10] = '{1'b1, 10'd300, 26'h3FFFFFF, 1'b1, 2'd3,
                 32'h7FC00000, 3'b000};
      vt[11] = '{1'b1, 10'd127, 26'h2000000, 1'b0, 2'd2,
                 32'hFF800000, 3'b000};
      vt[12] = '{1'b0, 10'd127, 26'h2000000, 1'b0, 2'd1,
                 32'h00000000, 3'b000};
      vt[13] = '{1'b1, 10'd0, 26'h1555555, 1'b1, 2'd1,
                 32'h80000000, 3'b000};
      vt[14] = '{1'b0, 10'd128, 26'h2000000, 1'b1, 2'd0,
                 32'h40000000, 3'b001};
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         run_one(vt[i], r, f, lat);
         total++;
         if (lat !== 2) begin
            bad++;
            $display("FAIL arith_lat[%0d] got=%0d exp=2", i, lat);
         end
         total++;
         if (r !== vt[i].r) begin
            bad++;
            $display("FAIL arith_res[%0d] got=%h exp=%h", i, r, vt[i].r);
         end
         total++;
         if (f !== vt[i].f) begin
            bad++;
            $display("FAIL arith_flags[%0d] got=%b exp=%b",
                     i, f, vt[i].f);
         end
      end
   endtask

   task automatic test_back_to_back;
      vec_t        vt [3];
      logic [31:0] exp_r [3];
      vt[0] = '{1'b1, 10'd0, 26'h0, 1'b0, 2'd1, 32'h0, 3'b0};
      vt[1] = '{1'b0, 10'd0, 26'h0, 1'b0, 2'd2, 32'h0, 3'b0};
      vt[2] = '{1'b0, 10'd128, 26'h2000000, 1'b0, 2'd0, 32'h0, 3'b0};
      exp_r[0] = 32'h80000000;
      exp_r[1] = 32'h7F800000;
      exp_r[2] = 32'h40000000;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2 && i < 5) begin
            total++;
            if (out_valid !== 1'b1 || out_res !== exp_r[i-2]) begin
               bad++;
               $display("FAIL b2b[%0d] got=%b/%h exp=1/%h",
                        i-2, out_valid, out_res, exp_r[i-2]);
            end
         end
         if (i < 3) begin
            total++;
            if (in_ready !== 1'b1) begin
               bad++;
               $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready);
            end
            drive(vt[i]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_backpressure;
      vec_t a;
      vec_t b;
      vec_t c;
      a = '{1'b0, 10'd128, 26'h2000000, 1'b0, 2'd0, 32'h0, 3'b0};
      b = '{1'b0, 10'd5, 26'h0, 1'b0, 2'd3, 32'h0, 3'b0};
      c = '{1'b1, 10'd5, 26'h0, 1'b0, 2'd2, 32'h0, 3'b0};
      @(negedge clk);
      out_ready = 1'b0;
      drive(a);
      in_valid = 1'b1;
      @(negedge clk);
      drive(b);
      @(negedge clk);
      drive(c);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready);
         end
         total++;
         if (out_valid !== 1'b1 || out_res !== 32'h40000000 ||
             {out_of, out_uf, out_nx} !== 3'b000) begin
            bad++;
            $display("FAIL bp_hold[%0d] got=%b/%h exp=1/40000000",
                     i, out_valid, out_res);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_res !== 32'h7FC00000) begin
         bad++;
         $display("FAIL bp_drain got=%b/%h exp=1/7fc00000",
                  out_valid, out_res);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_empty got=%b/%h exp=0", out_valid, out_res);
      end
   endtask

   task automatic test_reset_mid;
      vec_t        a;
      logic [31:0] r;
      logic [2:0]  f;
      int          lat;
      a = '{1'b0, 10'd300, 26'h2000000, 1'b0, 2'd0, 32'h0, 3'b0};
      @(negedge clk);
      out_ready = 1'b0;
      drive(a);
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pre got=%b exp=1", out_valid);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_async got=%b/%b exp=0/1",
                  out_valid, in_ready);
      end
      total++;
      if ({out_res, out_of, out_uf, out_nx} !== 35'd0) begin
         bad++;
         $display("FAIL rstmid_res got=%h/%b%b%b exp=0",
                  out_res, out_of, out_uf, out_nx);
      end
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_stale[%0d] got=%b exp=0", i, out_valid);
         end
      end
      a = '{1'b0, 10'd128, 26'h2000000, 1'b0, 2'd0, 32'h0, 3'b0};
      run_one(a, r, f, lat);
      total++;
      if (lat !== 2 || r !== 32'h40000000 || f !== 3'b000) begin
         bad++;
         $display("FAIL rstmid_after got=%0d/%h/%b exp=2/40000000/000",
                  lat, r, f);
      end
   endtask

   initial begin
      test_reset;
      test_arith;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_div_round.md
# fp_div_round

Normalize/round/pack stage that sits directly downstream of the mantissa divider in the FP divide datapath. It takes the raw fixed-point mantissa quotient, the remainder-nonzero indication, the sign and the pre-biased exponent. It produces a packed IEEE-754 result with exception flags. The block is a two-stage valid/ready pipeline with full backpressure.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; quotient width Q_W = MAN_W+3
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_sign  in  1  result sign (sa ^ sb)
- in_exp  in  EXP_W+2  signed biased exponent, ea - eb + bias
- in_q  in  Q_W  quotient, bit Q_W-1 weight 2^0, bit 0 weight 2^-(MAN_W+2); value in (0.5, 2)
- in_rem_nz  in  1  divider remainder nonzero
- in_cls  in  2  operand class from unpack: 00 normal, 01 zero, 10 inf, 11 nan
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  1+EXP_W+MAN_W  packed {sign, exp, frac}
- out_of, out_uf, out_nx  out  1 each  overflow, underflow, inexact

## Operation
- Stage 1, normalize:
  - If q[Q_W-1]=1: frac = q[MAN_W+1:2], guard = q[1], sticky = q[0] | rem_nz, e = in_exp.
  - Else: frac = q[MAN_W:1], guard = q[0], sticky = rem_nz, e = in_exp - 1.
  - Class and sign travel with the beat.
- Stage 2, round and pack:
  - inc = guard & (sticky | frac[0]).
  - frac+inc is computed MAN_W+1 wide. On carry-out, frac = 0 and e = e+1.
  - e >= 2^EXP_W-1: ±inf, of=1, nx=1.
  - e <= 0: flush to ±0, uf=1, nx=1. No subnormals.
  - Otherwise: normal pack, nx = guard | sticky.
- Class bypass overrides the arithmetic path, with priority nan > inf > zero:
  - nan: 0x7FC00000 pattern (sign 0, MSB of frac set).
  - inf: {sign, all-ones exponent, 0}.
  - zero: {sign, 0, 0}.
  - Flags are 0 on bypass.
- All exponent arithmetic is signed EXP_W+2 bits, with no wrap.

## Timing
- Latency: 2 cycles from in_valid&in_ready to out_valid, when there is no backpressure. Throughput is 1 beat/cycle.
- Advance rules:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready).
- While out_valid=1 and out_ready=0, out_res and the flags hold stable.
- A full pipeline under stall holds exactly 2 beats and drops in_ready. Simultaneous accept and drain in the same cycle is allowed, with no bubble inserted.
- Reset (rst=0, any time): s1_valid, s2_valid, out_valid, out_res and all flags go to 0 immediately. In-flight beats are discarded. in_ready=1 after reset.

## Configuration
- FP_DIV_RNE_EN defined: round-to-nearest-even, as described above.
- Not defined: round toward zero. inc = 0 and the carry path is absent; out_nx is still reported from guard|sticky.
- Overflow with the macro undefined: saturate to ±max finite, {sign, 2^EXP_W-2, all-ones}, with of=1.

## Structure
- Package fp_div_pkg:
  - cls_e enum (CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN).
  - EXP_W/MAN_W defaults.
  - QNAN_FRAC constant.
  - Stage-1 beat struct.
- Sub-module fp_round_rne: combinational; takes frac/guard/sticky and returns rounded frac, carry and inexact. Instantiated once in stage 2.

## Test plan
- 6.0/3.0: in_q=0x2000000, rem_nz=0, in_exp=128, cls normal -> out_res=0x40000000, flags 0, out_valid 2 cycles after accept.
- 1.0/3.0: in_q=0x1555555, rem_nz=1, in_exp=126 -> 0x3EAAAAAB, nx=1. With FP_DIV_RNE_EN undefined -> 0x3EAAAAAA.
- Round carry: in_q=0x3FFFFFF, rem_nz=1, in_exp=127 -> 0x40000000, nx=1.
- Range limits:
  - in_exp=300, q top set -> 0x7F800000, of=1.
  - in_sign=1, in_exp=0, in_q=0x1555555 -> 0x80000000, uf=1.
- Bypass: cls=11 -> 0x7FC00000. cls=10 with sign 1 -> 0xFF800000. cls=01 -> 0x00000000. Flags 0 for all three.
- Backpressure and reset:
  - Hold out_ready=0 and offer 3 beats -> 2 accepted, in_ready=0, out_res stable; releasing out_ready drains the beats in order.
  - Assert rst=0 mid-stream -> out_valid=0 that cycle, no stale beat afterwards.
